// File: rtl/shift_register_pkg.sv
// Shared constants for the shift_register block: shift direction encodings
// and the default register width.
package shift_register_pkg;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam int SHIFT_REGISTER_DEFAULT_WIDTH = 8;

endpackage : shift_register_pkg

// File: rtl/shift_register.sv
// Parallel-load, bidirectional serial-in shift register.
// Load has priority over shift. A left shift moves bits toward the MSB and
// inserts ser_in at bit 0. A right shift moves bits toward the LSB and
// inserts ser_in at the MSB. Bits shifted off either end are normally
// dropped.
// Optional feature macro: SHIFT_REGISTER_SER_OUT_EN adds a registered
// ser_out port. It holds the bit most recently shifted out of the register.
module shift_register
   import shift_register_pkg::*;
#(
   parameter int WIDTH = SHIFT_REGISTER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift,
   input  logic             load,
   input  logic             dir,
   input  logic [WIDTH-1:0] data,
   input  logic             ser_in,
`ifdef SHIFT_REGISTER_SER_OUT_EN
   output logic             ser_out,
`endif
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] shl_val;
   logic [WIDTH-1:0] shr_val;

   // Both candidate shift results are always computed. The select below
   // then stays a flat mux and has no arithmetic on the control path.
   always_comb begin
      shl_val = {q_q[WIDTH-2:0], ser_in};
      shr_val = {ser_in, q_q[WIDTH-1:1]};
   end

`ifdef SHIFT_REGISTER_SER_OUT_EN
   logic ser_out_d;
   logic ser_out_q;

   // Next-state selection with priority load > shift > hold; ser_out only
   // captures the bit that falls off the end during a shift.
   always_comb begin
      q_d       = q_q;
      ser_out_d = ser_out_q;
      if (load) begin
         q_d = data;
      end else if (shift) begin
         if (dir == DIR_LEFT) begin
            q_d       = shl_val;
            ser_out_d = q_q[WIDTH-1];
         end else begin
            q_d       = shr_val;
            ser_out_d = q_q[0];
         end
      end
   end

   // State flops; reset clears the register and the serial output at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q       <= '0;
         ser_out_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         ser_out_q <= ser_out_d;
      end
   end

   assign ser_out = ser_out_q;
`else
   // Next-state selection with priority load > shift > hold.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = data;
      end else if (shift) begin
         if (dir == DIR_LEFT) begin
            q_d = shl_val;
         end else begin
            q_d = shr_val;
         end
      end
   end

   // State flops; reset clears the register at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end
`endif

   assign q = q_q;

endmodule : shift_register

// File: tb/tb_shift_register.sv
// Scoreboard testbench for shift_register (8-bit default width).
// The stimulus process drives one vector per cycle on the falling edge and
// queues the expected register state. A monitor pops the queue after each
// rising edge and compares. Define SHIFT_REGISTER_SER_OUT_EN to also check
// ser_out.
module tb_shift_register;

   localparam int W = 8;

   typedef struct packed {
      logic         rst;
      logic         load;
      logic         shift;
      logic         dir;
      logic [W-1:0] data;
      logic         ser_in;
      logic [W-1:0] exp_q;
      logic         exp_so;
   } vec_t;

   typedef struct packed {
      int           idx;
      logic [W-1:0] exp_q;
      logic         exp_so;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         shift = 1'b0;
   logic         load = 1'b0;
   logic         dir = 1'b0;
   logic [W-1:0] data = '0;
   logic         ser_in = 1'b0;
   logic [W-1:0] q;
   logic         ser_out_obs;

   int checks = 0;
   int failures = 0;
   exp_t exp_queue[$];

`ifdef SHIFT_REGISTER_SER_OUT_EN
   logic ser_out;
   assign ser_out_obs = ser_out;
`else
   assign ser_out_obs = 1'b0;
`endif

   shift_register #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .shift  (shift),
      .load   (load),
      .dir    (dir),
      .data   (data),
      .ser_in (ser_in),
`ifdef SHIFT_REGISTER_SER_OUT_EN
      .ser_out(ser_out),
`endif
      .q      (q)
   );

   always #5 clk = ~clk;

   // Directed vectors with hand-computed results.
   // Columns: rst load shift dir data ser_in exp_q exp_so.
   localparam int N_A = 19;
   localparam int N_B = 4;
   vec_t vec_a [N_A] = '{
      '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0},
      '{1'b1,1'b0,1'b0,1'b1,8'hFF,1'b1,8'h00,1'b0},
      '{1'b1,1'b0,1'b0,1'b0,8'h3C,1'b1,8'h00,1'b0},
      '{1'b1,1'b0,1'b0,1'b1,8'hA5,1'b0,8'h00,1'b0},
      '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0},
      '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0},
      '{1'b0,1'b0,1'b0,1'b0,8'hFF,1'b1,8'h00,1'b0},
      '{1'b0,1'b1,1'b0,1'b0,8'hAA,1'b0,8'hAA,1'b0},
      '{1'b0,1'b0,1'b0,1'b0,8'h55,1'b1,8'hAA,1'b0},
      '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b1,8'h55,1'b1},
      '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b1,8'hAB,1'b0},
      '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h56,1'b1},
      '{1'b0,1'b0,1'b1,1'b1,8'h00,1'b0,8'h2B,1'b0},
      '{1'b0,1'b0,1'b1,1'b1,8'h00,1'b1,8'h95,1'b1},
      '{1'b0,1'b0,1'b1,1'b1,8'h00,1'b1,8'hCA,1'b1},
      '{1'b0,1'b0,1'b0,1'b1,8'h00,1'b0,8'hCA,1'b1},
      '{1'b0,1'b0,1'b0,1'b1,8'h00,1'b1,8'hCA,1'b1},
      '{1'b0,1'b0,1'b0,1'b1,8'h00,1'b1,8'hCA,1'b1},
      '{1'b0,1'b1,1'b1,1'b1,8'hF0,1'b1,8'hF0,1'b1}
   };
   vec_t vec_b [N_B] = '{
      '{1'b0,1'b1,1'b0,1'b0,8'h80,1'b0,8'h80,1'b0},
      '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,1'b1},
      '{1'b0,1'b0,1'b1,1'b1,8'h00,1'b1,8'h80,1'b0},
      '{1'b0,1'b0,1'b1,1'b1,8'h00,1'b0,8'h40,1'b0}
   };

   task automatic checkOutput(input string name, input logic [W-1:0] act_q,
                              input logic [W-1:0] exp_q, input logic act_so,
                              input logic exp_so);
      checks++;
      if (act_q !== exp_q) begin
         failures++;
         $display("[TB] FAIL %s q: got %b expected %b", name, act_q, exp_q);
      end
`ifdef SHIFT_REGISTER_SER_OUT_EN
      checks++;
      if (act_so !== exp_so) begin
         failures++;
         $display("[TB] FAIL %s ser_out: got %b expected %b", name, act_so, exp_so);
      end
`else
      if (act_so !== exp_so && 1'b0) failures++;
`endif
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      exp_t e;
      @(negedge clk);
      rst    = v.rst;
      load   = v.load;
      shift  = v.shift;
      dir    = v.dir;
      data   = v.data;
      ser_in = v.ser_in;
      e.idx    = idx;
      e.exp_q  = v.exp_q;
      e.exp_so = v.exp_so;
      exp_queue.push_back(e);
   endtask

   // Monitor: after every rising edge, compare the register against the
   // oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_queue.size() > 0) begin
            e = exp_queue.pop_front();
            checkOutput($sformatf("vec%0d", e.idx), q, e.exp_q, ser_out_obs, e.exp_so);
         end
      end
   end

   // Stimulus: directed sequence, mid-run asynchronous reset, then the tail.
   initial begin
      exp_t e;
      int waited;
      for (int i = 0; i < N_A; i++) applyStimulus(vec_a[i], i);

      // Arm a load and shift, then assert reset between edges. q must clear
      // before the next edge, and the armed load must be lost.
      @(negedge clk);
      load  = 1'b1;
      shift = 1'b1;
      data  = 8'hFF;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset", q, 8'h00, ser_out_obs, 1'b0);
      e.idx    = 100;
      e.exp_q  = 8'h00;
      e.exp_so = 1'b0;
      exp_queue.push_back(e);

      for (int i = 0; i < N_B; i++) applyStimulus(vec_b[i], 200 + i);

      @(negedge clk);
      load  = 1'b0;
      shift = 1'b0;
      waited = 0;
      while (exp_queue.size() > 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (exp_queue.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", exp_queue.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_shift_register

// File: doc/shift_register.md
# shift_register

Parallel-load, bidirectional serial-in shift register with a default width of 8 bits. It is a general-purpose datapath element: sequence detectors and serializers use it to capture a word in parallel, then shift serial bits in from either end. All state updates occur on the rising clock edge. The register clears asynchronously on reset.

## Interface
- WIDTH, default 8: register width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset; clears q immediately.
- shift  input  1  shift enable; sampled on clk rise.
- load  input  1  parallel-load enable; sampled on clk rise.
- dir  input  1  shift direction: 0 = left (toward MSB), 1 = right (toward LSB).
- data  input  WIDTH  parallel load value.
- ser_in  input  1  serial bit inserted at the vacated end during a shift.
- q  output  WIDTH  register contents, driven directly from flops.
- ser_out  output  1  bit most recently shifted out; present only with SHIFT_REGISTER_SER_OUT_EN.

## Operation
- Priority on each clk rise: rst, then load, then shift, then hold.
- rst = 1: q = 0 asynchronously. It stays 0 while rst is held. The first update happens on the first clk rise after deassertion.
- load = 1: q <= data. shift, dir and ser_in are ignored.
- load = 0, shift = 1, dir = 0: q <= {q[WIDTH-2:0], ser_in}. q[WIDTH-1] is discarded.
- load = 0, shift = 1, dir = 1: q <= {ser_in, q[WIDTH-1:1]}. q[0] is discarded.
- load = 0, shift = 0: q holds. dir, ser_in and data have no effect.
- Simultaneous load and shift: load wins and no shift occurs.
- Reset mid-operation: any pending load or shift is lost and q = 0.
- No wrap-around: shifted-out bits are dropped unless SHIFT_REGISTER_SER_OUT_EN is defined.

## Timing
- Latency is one cycle: a control applied before edge N is visible on q after edge N.
- Reset assertion is asynchronous. Deassertion is expected to be synchronous to clk, and the bench releases it away from the clock edge.
- q has no combinational path from any input; it is purely registered.
- A shift occurs on every edge that shift is high. There is no handshake or ready signal.

## Configuration
- SHIFT_REGISTER_SER_OUT_EN defined:
  - Adds the registered ser_out port.
  - On a shift with dir = 0, ser_out <= q[WIDTH-1]; with dir = 1, ser_out <= q[0].
  - On load or hold, ser_out holds.
  - Reset clears ser_out to 0.
- SHIFT_REGISTER_SER_OUT_EN undefined: the ser_out port and its flop do not exist. Behaviour of q is identical in both builds.

## Structure
- Shared package shift_register_pkg holds:
  - localparam DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1.
  - the default width constant SHIFT_REGISTER_DEFAULT_WIDTH = 8.
- No sub-module is natural. The block is one always_ff with async reset plus next-state selection logic.

## Test plan
- Reset: hold rst = 1 for 5 cycles with load = 0 and shift = 0 -> q = 00000000 throughout. Release -> q stays 00000000 while shift = 0 and load = 0.
- Load: load = 1, data = 10101010 for one cycle -> q = 10101010. Then load = 0, shift = 0 -> q holds 10101010.
- Shift left: from 10101010, three cycles of dir = 0 with ser_in = 1, 1, 0 -> q = 01010101, then 10101011, then 01010110.
- Shift right: from 01010110, three cycles of dir = 1 with ser_in = 0, 1, 1 -> q = 00101011, then 10010101, then 11001010.
- Shift disabled: shift = 0 for three cycles while dir = 1 and ser_in toggles 0, 1, 1 -> q stays 11001010.
- Priority and reset: load = 1 and shift = 1 together with data = 11110000 -> q = 11110000 with no shift. Assert rst between clock edges -> q = 00000000 immediately, before the next edge. With SHIFT_REGISTER_SER_OUT_EN, a left shift of 10000000 -> ser_out = 1.
